// File: rtl/or_gate.sv
// Bitwise OR of two WIDTH-bit operands: combinational result plus a registered
// copy carrying a valid flag and any/all/popcount summary flags.
module or_gate #(
    parameter int WIDTH = 5,
    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    input  logic             in_valid,
    output logic             out_valid,
    output logic [WIDTH-1:0] z_q,
    output logic             any_q,
    output logic             all_q,
    output logic [CW-1:0]    ones_q
);

    // Handshake: in_valid qualifies a/b at the rising edge; out_valid is high for
    // exactly the cycle after a qualified capture. No ready - every valid is taken.
    logic [CW-1:0] ones_d;

    assign z = a | b;

    always_comb begin
        ones_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_d = ones_d + CW'(z[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            z_q       <= '0;
            any_q     <= 1'b0;
            all_q     <= 1'b0;
            ones_q    <= '0;
        end else begin
            out_valid <= in_valid;
            // Summary flags only refresh alongside z_q so they always describe it.
            if (in_valid) begin
                z_q    <= z;
                any_q  <= |z;
                all_q  <= &z;
                ones_q <= ones_d;
            end
        end
    end

endmodule

// File: tb/tb_or_gate.sv
// Directed and randomized checks of or_gate (WIDTH=5 plus a WIDTH=1 instance)
// against a queue-based reference model.
module tb_or_gate;

    localparam int W = 5;

    logic         clk;
    logic         rst;
    logic [W-1:0] a, b;
    logic         in_valid;
    logic [W-1:0] z, z_q;
    logic         out_valid, any_q, all_q;
    logic [2:0]   ones_q;

    logic a1, b1, z1, out_valid1, z_q1, any_q1, all_q1;
    logic ones_q1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_z;

    or_gate #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .z(z), .in_valid(in_valid),
        .out_valid(out_valid), .z_q(z_q), .any_q(any_q), .all_q(all_q), .ones_q(ones_q)
    );

    or_gate #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .z(z1), .in_valid(in_valid),
        .out_valid(out_valid1), .z_q(z_q1), .any_q(any_q1), .all_q(all_q1), .ones_q(ones_q1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input logic v);
        check("out_valid", {31'b0, out_valid}, {31'b0, v});
        check("z_q", {27'b0, z_q}, {27'b0, m_z});
        check("ones_q", {29'b0, ones_q}, $countones(m_z));
        check("any_q", {31'b0, any_q}, {31'b0, m_z != 0});
        check("all_q", {31'b0, all_q}, {31'b0, m_z == 5'b11111});
        check("w1_z_q", {31'b0, z_q1}, {31'b0, m_z[0]});
        check("w1_ones_q", {31'b0, ones_q1}, {31'b0, m_z[0]});
    endtask

    // driver: apply operands at negedge, check z, then check registered stage
    task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv, input logic v);
        @(negedge clk);
        a = av; b = bv; in_valid = v;
        a1 = av[0]; b1 = bv[0];
        if (v) exp_q.push_back(av | bv);
        #1;
        check("z", {27'b0, z}, {27'b0, av | bv});
        check("w1_z", {31'b0, z1}, {31'b0, av[0] | bv[0]});
        @(posedge clk);
        #1;
        if (v && exp_q.size() != 0) m_z = exp_q.pop_front();
        check_regs(v);
    endtask

    task automatic apply_reset_now();
        rst = 1'b1;
        exp_q.delete();
        m_z = '0;
        #1;
        check_regs(1'b0);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        a = 5'b00101; b = 5'b10000;
        a1 = 1'b1; b1 = 1'b0;
        m_z = '0;
        #1;
        // reset: registers clear with no clock edge, z still live
        apply_reset_now();
        check("z_in_reset", {27'b0, z}, 32'h15);

        // reset wins over a capture edge
        in_valid = 1'b1; a = 5'b11111; b = 5'b00000;
        @(posedge clk); #1;
        check_regs(1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        step(5'b00000, 5'b00000, 1'b1);   // all-zero
        step(5'b01010, 5'b10101, 1'b1);   // all-ones
        step(5'b00100, 5'b00110, 1'b1);   // overlap
        step(5'b00100, 5'b00110, 1'b1);
        step(5'b11000, 5'b00000, 1'b0);   // hold

        // random stream with asynchronous reset in the middle
        for (int i = 0; i < 10; i++) begin
            step(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), 1'b1);
            if (i == 5) begin
                #2;
                apply_reset_now();
                @(negedge clk);
                rst = 1'b0;
            end
        end

        // operands moving between edges: register takes the value present at the edge
        @(negedge clk);
        a = 5'b00001; b = 5'b00000; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0;
        #2;
        a = 5'b10010; b = 5'b00100; a1 = 1'b0; b1 = 1'b0;
        #1;
        check("z_moving", {27'b0, z}, 32'h16);
        @(posedge clk); #1;
        m_z = 5'b10110;
        check_regs(1'b1);

        step(5'b00000, 5'b00000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_gate.md
Name: or_gate

Overview:
- Parameterised bitwise-OR block: two WIDTH-bit operands combined bit-by-bit.
- Combinational result plus a one-cycle registered copy with a valid flag and summary flags (any/all/popcount).
- Used as a leaf datapath primitive.
- Sits between operand sources driven on the falling clock edge and consumers sampling on the rising edge.

Parameters:
- WIDTH, 5, operand/result bit width; legal range WIDTH >= 1.

Ports:
- clk  input  1  system clock; all registers update on rising edge
- rst  input  1  asynchronous, active-high reset for all registers
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- z  output  WIDTH  combinational result a | b
- in_valid  input  1  operands valid; qualifies capture into the registered stage
- out_valid  output  1  registered outputs hold a result captured on the previous edge
- z_q  output  WIDTH  registered a | b
- any_q  output  1  registered OR-reduction of (a | b)
- all_q  output  1  registered AND-reduction of (a | b)
- ones_q  output  CW  registered count of set bits in (a | b); CW = clog2(WIDTH+1), minimum 1

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Combinational path:
  - z[i] = a[i] | b[i] for every bit i; zero latency.
  - No dependence on clk, rst or in_valid; z follows a/b even while rst is high.
- Reset:
  - While rst = 1, out_valid, z_q, any_q, all_q and ones_q are 0 immediately, without waiting for a clock edge.
  - Registers leave reset on the first rising clk edge after rst deasserts.
- Capture (rising clk, rst = 0):
  - out_valid <= in_valid on every edge.
  - If in_valid = 1: z_q <= a | b; any_q <= |(a | b); all_q <= &(a | b); ones_q <= popcount(a | b).
  - If in_valid = 0: z_q, any_q, all_q and ones_q hold their previous values; out_valid goes to 0.
- Latency: registered outputs reflect operands present at the capturing edge; one cycle latency. Back-to-back in_valid gives one result per cycle. There is no backpressure.
- Arithmetic/width:
  - Popcount is unsigned, range 0..WIDTH. It never overflows CW.
  - For WIDTH = 1: CW = 1, ones_q equals z_q.
- Boundary cases:
  - All-zero operands give any_q = 0, all_q = 0, ones_q = 0.
  - All-ones result gives all_q = 1, ones_q = WIDTH.
  - Operands changing between edges affect z only.
  - rst asserted at the same time as a capture edge: reset wins and registers read 0.
  - rst asserted mid-stream clears registers and out_valid at once. The first valid capture after release produces out_valid = 1 on the following cycle.
- No internal state other than the registered stage. No X-propagation handling beyond standard RTL semantics.

Test Plan:
- Reset: rst = 1, a = 5'b00101, b = 5'b10000 -> z = 5'b10101 immediately; z_q = 0, out_valid = 0, ones_q = 0 with no clock edge required.
- Zero operands: rst = 0, in_valid = 1, a = 0, b = 0 at negedge -> after next posedge z_q = 0, any_q = 0, all_q = 0, ones_q = 0, out_valid = 1.
- Full coverage: a = 5'b01010, b = 5'b10101 -> z = 5'b11111; next posedge z_q = 5'b11111, all_q = 1, any_q = 1, ones_q = 5.
- Overlap: a = 5'b00100, b = 5'b00110 -> z = 5'b00110; next posedge ones_q = 2, any_q = 1, all_q = 0.
- Hold: capture 5'b00110, then in_valid = 0 with a = 5'b11000, b = 0 -> z = 5'b11000 immediately; z_q stays 5'b00110; out_valid = 0 after next posedge.
- Random stream: 10 random a/b pairs applied on successive negedges with in_valid = 1 -> each cycle z == a | b; z_q/ones_q match the previous pair's model. Assert rst asynchronously mid-stream -> registered outputs read 0 at once; results resume one cycle after first post-release capture.
